// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the IorD address mux and a word-wide synchronous memory.
// Handles word/half/byte accesses, read-modify-write for sub-word stores, and alignment faults.
//
// state      | meaning
// -----------+----------------------------------------------------------------
// S_IDLE     | waiting for req; all request fields sampled here
// S_RD_WAIT  | memory read in flight; down-counter runs to terminal count 0
// S_WR_WORD  | full-word write strobe on the memory port
// S_MERGE_WR | merged sub-word write strobe on the memory port
// S_FINISH   | done pulse (with misaligned for a fault), then back to idle
module mem_access_ctrl #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        op_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR_WORD,
    S_MERGE_WR,
    S_FINISH
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [2:0] LAT     = 3'(MEM_LATENCY);

  state_t      state;
  logic [2:0]  cnt;
  logic        op_wr_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic        fault_q;

  logic [1:0]  size_n;
  logic        fault_n;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  // Size 11 behaves exactly like a word access, so it is folded to word at the door.
  always_comb begin
    size_n  = (size == 2'b11) ? SZ_WORD : size;
    fault_n = ((size_n == SZ_WORD) && (addr[1:0] != 2'b00)) ||
              ((size_n == SZ_HALF) && addr[0]);
  end

  always_comb begin
    lane_b    = mem_rdata[{off_q, 3'b000} +: 8];
    lane_h    = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_val  = mem_rdata;
    merge_val = mem_rdata;
    case (size_q)
      SZ_HALF: begin
        load_val = {{16{sext_q & lane_h[15]}}, lane_h};
        merge_val[{off_q[1], 4'b0000} +: 16] = wdata_q;
      end
      SZ_BYTE: begin
        load_val = {{24{sext_q & lane_b[7]}}, lane_b};
        merge_val[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_wr_q    <= 1'b0;
      size_q     <= SZ_WORD;
      sext_q     <= 1'b0;
      off_q      <= 2'b00;
      wdata_q    <= '0;
      fault_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            busy    <= 1'b1;
            op_wr_q <= op_write;
            size_q  <= size_n;
            sext_q  <= sign_ext;
            off_q   <= addr[1:0];
            wdata_q <= wdata[15:0];
            if (fault_n) begin
              fault_q <= 1'b1;
              state   <= S_FINISH;
            end else begin
              mem_addr <= {addr[31:2], 2'b00};
              if (op_write && (size_n == SZ_WORD)) begin
                mem_wr    <= 1'b1;
                mem_wdata <= wdata;
                state     <= S_WR_WORD;
              end else begin
                cnt   <= LAT;
                state <= S_RD_WAIT;
              end
            end
          end
        end
        S_RD_WAIT: begin
          if (cnt == 3'd0) begin
            if (op_wr_q) begin
              mem_wr    <= 1'b1;
              mem_wdata <= merge_val;
              state     <= S_MERGE_WR;
            end else begin
              rdata <= load_val;
              done  <= 1'b1;
              state <= S_FINISH;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_WR_WORD, S_MERGE_WR: begin
          mem_wr <= 1'b0;
          done   <= 1'b1;
          state  <= S_FINISH;
        end
        S_FINISH: begin
          // A fault enters here straight from idle, so it spends one cycle before pulsing done.
          if (!done) begin
            done       <= 1'b1;
            misaligned <= fault_q;
          end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            fault_q    <= 1'b0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (latency 1 and 3), each with a small synchronous
// memory, checked every cycle against an operation-level reference model.
module tb_mem_access_ctrl;

  logic             clk;
  logic [1:0]       rst, req, op_write, sign_ext, busy, done, misal, mem_wr;
  logic [1:0][1:0]  size;
  logic [1:0][31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;

  int cyc, n_cmp, n_bad;

  // reference model state, one slot per instance
  int          op_n[2], op_d[2], op_wrc[2];
  bit          op_live[2], op_load[2], op_fault[2];
  logic [31:0] op_wexp[2], op_aexp[2], op_rd[2], exp_rdata[2];
  logic [31:0] shadow[2][16];
  bit          pend_wr[2];
  int          pend_idx[2];
  logic [31:0] pend_val[2];

  // observations
  int          done_seen[2], wr_seen[2], mis_seen[2], last_done[2];
  logic [31:0] last_wd[2], last_wa[2];

  logic be, de, me, we;

  function automatic logic [31:0] init_word(input int k);
    return (k == 4) ? 32'h8899AABB : (32'h10203040 + 32'(k));
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [31:0] mem [16];
    logic [31:0] pipe [4];

    mem_access_ctrl #(.MEM_LATENCY(L)) u_dut (
      .clk        (clk),
      .reset      (rst[g]),
      .req        (req[g]),
      .op_write   (op_write[g]),
      .size       (size[g]),
      .sign_ext   (sign_ext[g]),
      .addr       (addr[g]),
      .wdata      (wdata[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .misaligned (misal[g]),
      .rdata      (rdata[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wr     (mem_wr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g])
    );

    initial begin
      for (int k = 0; k < 16; k++) mem[k] = init_word(k);
      for (int k = 0; k < 4; k++) pipe[k] = '0;
    end

    always @(posedge clk) begin
      if (mem_wr[g]) mem[mem_addr[g][5:2]] <= mem_wdata[g];
      pipe[0] <= mem_addr[g];
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end

    assign mem_rdata[g] = mem[pipe[L-1][5:2]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] off, input bit sx);
    longint v;
    if (sz == 2'b01) begin
      v = longint'((w >> (16 * int'(off[1]))) & 32'hFFFF);
      if (sx && v >= 32768) v = v - 65536;
    end else if (sz == 2'b10) begin
      v = longint'((w >> (8 * int'(off))) & 32'hFF);
      if (sx && v >= 128) v = v - 256;
    end else begin
      v = longint'(w);
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] sz,
                                        input logic [1:0] off, input logic [31:0] d);
    int sh;
    logic [31:0] m;
    if (sz == 2'b01) begin
      sh = 16 * int'(off[1]);
      m  = 32'hFFFF << sh;
      return (w & ~m) | ((d & 32'hFFFF) << sh);
    end
    if (sz == 2'b10) begin
      sh = 8 * int'(off);
      m  = 32'hFF << sh;
      return (w & ~m) | ((d & 32'hFF) << sh);
    end
    return d;
  endfunction

  // Called at a falling edge; early=1 raises req while the previous op is still in its done cycle.
  task automatic start_op(input int i, input bit wr, input logic [1:0] sz, input bit sx,
                          input logic [31:0] a, input logic [31:0] wd, input bit early);
    int lat, n, w;
    bit word, fault;
    logic [1:0] off;
    logic [31:0] old;
    #1;
    lat   = (i == 0) ? 1 : 3;
    n     = cyc + (early ? 2 : 1);
    word  = (sz == 2'b00) || (sz == 2'b11);
    off   = a[1:0];
    w     = int'(a[5:2]);
    fault = (word && off != 2'b00) || (sz == 2'b01 && off[0]);
    old   = shadow[i][w];
    op_n[i]     = n;
    op_fault[i] = fault;
    op_load[i]  = !wr && !fault;
    op_wrc[i]   = -100;
    op_aexp[i]  = {a[31:2], 2'b00};
    pend_wr[i]  = 1'b0;
    if (fault) begin
      op_d[i] = n + 1;
    end else if (!wr) begin
      op_d[i]  = n + lat + 1;
      op_rd[i] = extract(old, sz, off, sx);
    end else begin
      op_wexp[i]  = merge(old, sz, off, wd);
      op_d[i]     = word ? n + 1 : n + lat + 2;
      op_wrc[i]   = word ? n : n + lat + 1;
      pend_wr[i]  = 1'b1;
      pend_idx[i] = w;
      pend_val[i] = op_wexp[i];
    end
    op_live[i]  = 1'b1;
    req[i]      = 1'b1;
    op_write[i] = wr;
    size[i]     = sz;
    sign_ext[i] = sx;
    addr[i]     = a;
    wdata[i]    = wd;
    repeat (early ? 2 : 1) @(negedge clk);
    #1 req[i] = 1'b0;
  endtask

  task automatic finish_op(input int i);
    while (cyc < op_d[i]) @(negedge clk);
    #1;
    if (pend_wr[i]) shadow[i][pend_idx[i]] = pend_val[i];
    pend_wr[i] = 1'b0;
  endtask

  task automatic do_op(input int i, input bit wr, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd);
    start_op(i, wr, sz, sx, a, wd, 1'b0);
    finish_op(i);
    @(negedge clk);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      be = op_live[i] && (cyc >= op_n[i]) && (cyc <= op_d[i]);
      de = op_live[i] && (cyc == op_d[i]);
      me = de && op_fault[i];
      we = op_live[i] && (cyc == op_wrc[i]);
      if (de && op_load[i]) exp_rdata[i] = op_rd[i];
      if (done[i]) begin
        done_seen[i]++;
        last_done[i] = cyc;
      end
      if (mem_wr[i]) begin
        wr_seen[i]++;
        last_wd[i] = mem_wdata[i];
        last_wa[i] = mem_addr[i];
      end
      if (misal[i]) mis_seen[i]++;
      chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(be));
      chk($sformatf("done[%0d]", i), 32'(done[i]), 32'(de));
      chk($sformatf("misaligned[%0d]", i), 32'(misal[i]), 32'(me));
      chk($sformatf("mem_wr[%0d]", i), 32'(mem_wr[i]), 32'(we));
      chk($sformatf("rdata[%0d]", i), rdata[i], exp_rdata[i]);
      if (we) chk($sformatf("mem_wdata[%0d]", i), mem_wdata[i], op_wexp[i]);
      if (be && !op_fault[i]) chk($sformatf("mem_addr[%0d]", i), mem_addr[i], op_aexp[i]);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int m0, w0, d0;

  initial begin
    cyc = 0; n_cmp = 0; n_bad = 0;
    rst = 2'b11; req = '0; op_write = '0; sign_ext = '0;
    size = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 2; i++) begin
      op_live[i] = 0; op_n[i] = 0; op_d[i] = 0; op_wrc[i] = -100;
      exp_rdata[i] = '0; pend_wr[i] = 0;
      done_seen[i] = 0; wr_seen[i] = 0; mis_seen[i] = 0; last_done[i] = 0;
      for (int k = 0; k < 16; k++) shadow[i][k] = init_word(k);
    end
    repeat (3) @(negedge clk);
    chk("reset_rdata", rdata[0], 32'h0);
    chk("reset_memaddr", mem_addr[1], 32'h0);
    #1 rst = 2'b00;
    @(negedge clk);

    // ---- latency 1 instance ----
    do_op(0, 0, 2'b10, 1, 32'h11, 32'h0);
    chk("lb_sx_0x11", rdata[0], 32'hFFFFFFAA);
    chk("lb_latency", 32'(last_done[0] - op_n[0]), 32'd2);
    chk("lb_no_write", 32'(wr_seen[0]), 32'd0);
    do_op(0, 0, 2'b01, 0, 32'h12, 32'h0);
    chk("lh_zx_0x12", rdata[0], 32'h00008899);
    do_op(0, 0, 2'b01, 1, 32'h12, 32'h0);
    chk("lh_sx_0x12", rdata[0], 32'hFFFF8899);
    do_op(0, 0, 2'b10, 0, 32'h10, 32'h0);
    chk("lb_zx_0x10", rdata[0], 32'h000000BB);
    do_op(0, 0, 2'b11, 1, 32'h10, 32'h0);
    chk("lw_size11", rdata[0], 32'h8899AABB);

    m0 = mis_seen[0];
    w0 = wr_seen[0];
    do_op(0, 0, 2'b00, 0, 32'h12, 32'h0);
    chk("lw_mis_rdata_kept", rdata[0], 32'h8899AABB);
    chk("lw_mis_latency", 32'(last_done[0] - op_n[0]), 32'd1);
    do_op(0, 1, 2'b01, 0, 32'h13, 32'hFFFF0000);
    chk("mis_pulses", 32'(mis_seen[0] - m0), 32'd2);
    chk("mis_no_write", 32'(wr_seen[0] - w0), 32'd0);

    w0 = wr_seen[0];
    do_op(0, 1, 2'b10, 0, 32'h13, 32'h123456CC);
    chk("sb_one_pulse", 32'(wr_seen[0] - w0), 32'd1);
    chk("sb_wdata", last_wd[0], 32'hCC99AABB);
    chk("sb_waddr", last_wa[0], 32'h00000010);
    chk("sb_mem", g_dut[0].mem[4], 32'hCC99AABB);
    chk("sb_rdata_kept", rdata[0], 32'h8899AABB);
    chk("sb_latency", 32'(last_done[0] - op_n[0]), 32'd3);

    do_op(0, 1, 2'b00, 0, 32'h18, 32'hDEADBEEF);
    chk("sw_latency", 32'(last_done[0] - op_n[0]), 32'd1);
    do_op(0, 0, 2'b00, 0, 32'h18, 32'h0);
    chk("lw_after_sw", rdata[0], 32'hDEADBEEF);

    // request raised during the done cycle is taken on the next idle cycle
    start_op(0, 0, 2'b10, 1, 32'h1A, 32'h0, 1'b0);
    finish_op(0);
    start_op(0, 0, 2'b01, 0, 32'h1A, 32'h0, 1'b1);
    finish_op(0);
    @(negedge clk);
    chk("b2b_lh", rdata[0], 32'h0000DEAD);

    // reset while the merged write is on the bus
    start_op(0, 1, 2'b10, 0, 32'h14, 32'h00000077, 1'b0);
    while (cyc < op_wrc[0]) @(negedge clk);
    #2 rst[0] = 1'b1;
    #1;
    chk("rst_memwr_drop", 32'(mem_wr[0]), 32'd0);
    chk("rst_busy_drop", 32'(busy[0]), 32'd0);
    op_live[0] = 1'b0;
    pend_wr[0] = 1'b0;
    exp_rdata[0] = '0;
    repeat (2) @(negedge clk);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    do_op(0, 0, 2'b00, 0, 32'h14, 32'h0);
    chk("post_rst_lw", rdata[0], 32'h10203045);

    // ---- latency 3 instance ----
    do_op(1, 0, 2'b10, 0, 32'h10, 32'h0);
    chk("l3_lb", rdata[1], 32'h000000BB);
    chk("l3_lb_latency", 32'(last_done[1] - op_n[1]), 32'd4);

    d0 = done_seen[1];
    start_op(1, 0, 2'b00, 0, 32'h10, 32'h0, 1'b0);
    req[1] = 1'b1; op_write[1] = 1'b1; size[1] = 2'b00;
    addr[1] = 32'h20; wdata[1] = 32'hBADBAD00;
    @(negedge clk);
    #1 req[1] = 1'b0;
    finish_op(1);
    repeat (3) @(negedge clk);
    chk("busy_req_ignored", 32'(done_seen[1] - d0), 32'd1);
    chk("busy_req_no_write", 32'(wr_seen[1]), 32'd0);
    chk("l3_lw", rdata[1], 32'h8899AABB);

    do_op(1, 1, 2'b01, 0, 32'h10, 32'h0000BEEF);
    chk("l3_sh_mem", g_dut[1].mem[4], 32'h8899BEEF);
    chk("l3_sh_latency", 32'(last_done[1] - op_n[1]), 32'd5);
    do_op(1, 0, 2'b01, 1, 32'h10, 32'h0);
    chk("l3_lh_sx", rdata[1], 32'hFFFFBEEF);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
